// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//   Runs 32-bit LSU load/store requests against an external 16-bit
//   asynchronous SRAM. Each word access is two halfword phases, low half
//   first. Each phase is a strobe window of WAIT_CYC cycles followed by one
//   recovery cycle. The LSU side uses a one-cycle request pulse and a
//   one-cycle ack.
//
// Parameters
//   WAIT_CYC    strobe-active cycles per halfword phase (1..15)
//
// Optional build macro
//   SRAM_CTRL_MASKSKIP_EN  when defined, a write skips any halfword phase
//                          whose two byte-mask bits are both clear
//
// Ports
//   i_clk, i_rst   clock; asynchronous active-high reset
//   i_req          request pulse, sampled only while o_busy=0
//   i_wren         1=write, 0=read (qualified by i_req)
//   i_addr[18:0]   byte address; bits [1:0] ignored
//   i_wdata[31:0]  store data
//   i_bmask[3:0]   byte enables for writes (bit n -> byte n)
//   o_rdata[31:0]  load data; held until the next read capture
//   o_ack          one-cycle completion pulse
//   o_busy         high in every state except IDLE
//   SRAM_DQ        bidirectional SRAM data bus
//   SRAM_ADDR      SRAM halfword address
//   SRAM_CE_N/WE_N/OE_N/LB_N/UB_N  active-low SRAM controls
// ---------------------------------------------------------------------------
module sram_ctrl #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_wren,
    input  logic [18:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_bmask,
    output logic [31:0] o_rdata,
    output logic        o_ack,
    output logic        o_busy,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N
);

    typedef enum logic [2:0] {
        IDLE,
        LO_STB,
        LO_REC,
        HI_STB,
        HI_REC,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wren_q;
    logic [16:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  bmask_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        lo_phase;
    logic        hi_phase;
    logic        stb;
    logic        dq_oe;
    logic [15:0] dq_out;

    // Byte-offset bits of the address carry no information for word accesses.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^i_addr[1:0];

    assign accept = (state_q == IDLE) && i_req;

    // -----------------------------------------------------------------------
    // State register and request latch
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bmask_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wren_q  <= i_wren;
                addr_q  <= i_addr[18:2];
                wdata_q <= i_wdata;
                bmask_q <= i_bmask;
            end
            // Capture on the edge that closes the final strobe cycle of a phase.
            if (!wren_q && cnt_q == '0) begin
                if (state_q == LO_STB) rdata_q[15:0]  <= SRAM_DQ;
                if (state_q == HI_STB) rdata_q[31:16] <= SRAM_DQ;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic and SRAM-side decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (i_req) begin
                    state_d = LO_STB;
                    cnt_d   = CNT_LOAD;
`ifdef SRAM_CTRL_MASKSKIP_EN
                    if (i_wren) begin
                        if (i_bmask == 4'b0000) begin
                            state_d = DONE;
                        end else if (i_bmask[1:0] == 2'b00) begin
                            state_d = HI_STB;
                        end
                    end
`endif
                end
            end
            LO_STB: begin
                if (cnt_q == '0) begin
                    state_d = LO_REC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            LO_REC: begin
                state_d = HI_STB;
                cnt_d   = CNT_LOAD;
`ifdef SRAM_CTRL_MASKSKIP_EN
                if (wren_q && bmask_q[3:2] == 2'b00) begin
                    state_d = DONE;
                end
`endif
            end
            HI_STB: begin
                if (cnt_q == '0) begin
                    state_d = HI_REC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HI_REC: state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lo_phase  = (state_q == LO_STB) || (state_q == LO_REC);
        hi_phase  = (state_q == HI_STB) || (state_q == HI_REC);
        stb       = (state_q == LO_STB) || (state_q == HI_STB);

        SRAM_ADDR = '0;
        SRAM_CE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_LB_N = 1'b1;
        SRAM_UB_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;

        if (lo_phase || hi_phase) begin
            SRAM_ADDR = {addr_q, hi_phase};
            SRAM_CE_N = 1'b0;
            if (wren_q) begin
                SRAM_WE_N = !stb;
                SRAM_LB_N = hi_phase ? !bmask_q[2] : !bmask_q[0];
                SRAM_UB_N = hi_phase ? !bmask_q[3] : !bmask_q[1];
                // Data stays on the bus through the recovery cycle for hold time.
                dq_oe     = 1'b1;
                dq_out    = hi_phase ? wdata_q[31:16] : wdata_q[15:0];
            end else begin
                SRAM_OE_N = !stb;
                SRAM_LB_N = 1'b0;
                SRAM_UB_N = 1'b0;
            end
        end
    end

    assign SRAM_DQ = dq_oe ? dq_out : 'z;

    assign o_rdata = rdata_q;
    assign o_ack   = (state_q == DONE);
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
//   Self-checking bench for sram_ctrl. A behavioural SRAM sits on the bus.
//   A word-level reference memory predicts load data. Expected latency and
//   strobe counts come from phase arithmetic.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int unsigned W  = 1;
    localparam int unsigned W3 = 3;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // main DUT signals
    logic        req, wren;
    logic [18:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic [31:0] rdata;
    logic        ack, busy;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;

    // second DUT (WAIT_CYC=3) signals
    logic        req3;
    logic [31:0] rdata3;
    logic        ack3, busy3;
    wire  [15:0] sram_dq3;
    logic [17:0] sram_addr3;
    logic        ce3_n, we3_n, oe3_n, lb3_n, ub3_n;

    sram_ctrl #(.WAIT_CYC(W)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_wren(wren), .i_addr(addr),
        .i_wdata(wdata), .i_bmask(bmask), .o_rdata(rdata), .o_ack(ack),
        .o_busy(busy), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
        .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
    );

    sram_ctrl #(.WAIT_CYC(W3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_req(req3), .i_wren(1'b1),
        .i_addr(19'h00010), .i_wdata(32'h12345678), .i_bmask(4'hF),
        .o_rdata(rdata3), .o_ack(ack3), .o_busy(busy3), .SRAM_DQ(sram_dq3),
        .SRAM_ADDR(sram_addr3), .SRAM_CE_N(ce3_n), .SRAM_WE_N(we3_n),
        .SRAM_OE_N(oe3_n), .SRAM_LB_N(lb3_n), .SRAM_UB_N(ub3_n)
    );

    // Behavioural asynchronous SRAM (512 halfwords are enough for the bench).
    logic [15:0] sram_mem [0:511];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr[8:0]] : 'z;

    always @(negedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) sram_mem[sram_addr[8:0]][7:0]  <= sram_dq[7:0];
            if (!ub_n) sram_mem[sram_addr[8:0]][15:8] <= sram_dq[15:8];
        end
    end

    // Word-level reference memory.
    logic [31:0] ref_mem [0:255];
    logic [31:0] last_rd;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int phases_run(input bit wr, input logic [3:0] bm);
        int ph;
        ph = 2;
`ifdef SRAM_CTRL_MASKSKIP_EN
        if (wr) ph = int'(|bm[1:0]) + int'(|bm[3:2]);
`endif
        return ph;
    endfunction

    task automatic run_txn(input bit wr, input logic [16:0] word, input logic [31:0] wd,
                           input logic [3:0] bm, input bit pulse);
        int n, we_cnt, oe_cnt, ce_cnt, extra, ph;
        bit acked, seen_hi;
        logic [15:0] exp_dq;
        logic [1:0]  exp_lanes;
        n = 0; we_cnt = 0; oe_cnt = 0; ce_cnt = 0; extra = 0;
        acked = 1'b0; seen_hi = 1'b0;
        ph = phases_run(wr, bm);

        @(negedge clk);
        check("idle_before", {31'd0, busy}, 32'd0);
        req = 1'b1; wren = wr; addr = {word, 2'($urandom)}; wdata = wd; bmask = bm;
        @(posedge clk);
        #1;
        // Scramble request inputs; the controller must use its latched copy.
        req = 1'b0; wren = 1'($urandom); addr = 19'($urandom);
        wdata = $urandom; bmask = 4'($urandom);

        while (!acked && n < 64) begin
            @(negedge clk);
            n++;
            if (!ce_n) begin
                ce_cnt++;
                check("addr_word", {15'd0, sram_addr[17:1]}, {15'd0, word});
                if (sram_addr[0]) seen_hi = 1'b1;
                else check("lo_after_hi", {31'd0, seen_hi}, 32'd0);
                exp_lanes = wr ? (sram_addr[0] ? ~bm[3:2] : ~bm[1:0]) : 2'b00;
                check("lanes", {30'd0, ub_n, lb_n}, {30'd0, exp_lanes});
                if (wr) begin
                    exp_dq = sram_addr[0] ? wd[31:16] : wd[15:0];
                    check("wr_dq", {16'd0, sram_dq}, {16'd0, exp_dq});
                end
            end
            if (!we_n) we_cnt++;
            if (!oe_n) oe_cnt++;
            if (ack) acked = 1'b1;
            if (pulse && n == 2) req = 1'b1;
            if (pulse && n == 3) req = 1'b0;
        end
        req = 1'b0;

        check("latency", n, ph * (W + 1) + 1);
        check("ce_cycles", ce_cnt, ph * (W + 1));
        check("we_cycles", we_cnt, wr ? ph * W : 0);
        check("oe_cycles", oe_cnt, wr ? 0 : 2 * W);

        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (bm[b]) ref_mem[word][8*b +: 8] = wd[8*b +: 8];
            check("rdata_hold", rdata, last_rd);
        end else begin
            check("rdata", rdata, ref_mem[word]);
            last_rd = ref_mem[word];
        end

        // Exactly one ack: nothing further, and idle right after DONE.
        for (int k = 0; k < (pulse ? 8 : 1); k++) begin
            @(negedge clk);
            if (ack) extra++;
        end
        check("single_ack", extra, 0);
        check("idle_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n3, extra3;
        bit acked3;
        logic [31:0] r;

        for (int i = 0; i < 256; i++) begin
            r = $urandom;
            ref_mem[i] = r;
            sram_mem[2*i]   = r[15:0];
            sram_mem[2*i+1] = r[31:16];
        end
        last_rd = '0;
        req = 0; wren = 0; addr = '0; wdata = '0; bmask = '0; req3 = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {27'd0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_ack_busy", {30'd0, ack, busy}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        // Directed: full write, read back, partial write, read back.
        run_txn(1'b1, 17'd1, 32'hDEADBEEF, 4'hF, 1'b0);
        run_txn(1'b0, 17'd1, 32'h0, 4'h0, 1'b0);
        check("dir_read1", rdata, 32'hDEADBEEF);
        run_txn(1'b1, 17'd1, 32'h0000AB00, 4'h2, 1'b0);
        run_txn(1'b0, 17'd1, 32'h0, 4'h0, 1'b0);
        check("dir_read2", rdata, 32'hDEADABEF);

        // Request pulse while busy is dropped.
        run_txn(1'b1, 17'd2, 32'h01020304, 4'hF, 1'b1);
        // Empty mask write, then confirm contents unchanged.
        run_txn(1'b1, 17'd3, 32'hFFFFFFFF, 4'h0, 1'b0);
        run_txn(1'b0, 17'd3, 32'h0, 4'h0, 1'b0);
        // Each single upper-half / lower-half mask.
        run_txn(1'b1, 17'd4, 32'hA5A5C3C3, 4'hC, 1'b0);
        run_txn(1'b1, 17'd5, 32'h5A5A3C3C, 4'h3, 1'b0);
        run_txn(1'b0, 17'd4, 32'h0, 4'h0, 1'b0);
        run_txn(1'b0, 17'd5, 32'h0, 4'h0, 1'b0);

        // Asynchronous reset during a write's low strobe.
        @(negedge clk);
        req = 1'b1; wren = 1'b1; addr = {17'd100, 2'b00}; wdata = 32'hCAFEF00D; bmask = 4'hF;
        @(posedge clk);
        #1 req = 1'b0;
        #1;
        check("mid_we_low", {31'd0, we_n}, 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_ctrl", {27'd0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        check("mid_rst_addr", {14'd0, sram_addr}, 32'd0);
        check("mid_rst_ack_busy", {30'd0, ack, busy}, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        last_rd = '0;
        @(negedge clk);
        rst = 1'b0;
        run_txn(1'b0, 17'd100, 32'h0, 4'h0, 1'b0);

        // Randomised traffic.
        for (int t = 0; t < 40; t++)
            run_txn(1'($urandom), 17'($urandom_range(0, 63)), $urandom, 4'($urandom), 1'b0);

        // WAIT_CYC=3 instance: latency and dropped pulse.
        @(negedge clk);
        req3 = 1'b1;
        @(posedge clk);
        #1 req3 = 1'b0;
        n3 = 0; acked3 = 1'b0; extra3 = 0;
        while (!acked3 && n3 < 64) begin
            @(negedge clk);
            n3++;
            if (ack3) acked3 = 1'b1;
            if (n3 == 2) req3 = 1'b1;
            if (n3 == 3) req3 = 1'b0;
        end
        check("w3_latency", n3, 2 * (W3 + 1) + 1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ack3) extra3++;
        end
        check("w3_single_ack", extra3, 0);
        check("w3_idle", {31'd0, busy3}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Sequences 32-bit load/store requests from the LSU onto the board's external 16-bit asynchronous SRAM (18-bit halfword address, LB/UB byte lanes). Each word access is split into two halfword phases, low half first, with programmable strobe width. The LSU sees a single-cycle request pulse and a single-cycle ack.

Parameters:
WAIT_CYC, 1, strobe-active cycles per halfword phase; legal values 1 to 15.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_req  in  1  request pulse; sampled only when o_busy=0
i_wren  in  1  1=write, 0=read; qualified by i_req
i_addr  in  19  byte address; bits [1:0] ignored
i_wdata  in  32  store data
i_bmask  in  4  byte enables for writes; bit n enables byte n; ignored for reads
o_rdata  out  32  load data
o_ack  out  1  one-cycle completion pulse
o_busy  out  1  high in every state except IDLE
SRAM_DQ  inout  16  SRAM data bus
SRAM_ADDR  out  18  SRAM halfword address
SRAM_CE_N  out  1  chip enable, active-low
SRAM_WE_N  out  1  write enable, active-low
SRAM_OE_N  out  1  output enable, active-low
SRAM_LB_N  out  1  lower byte lane, active-low
SRAM_UB_N  out  1  upper byte lane, active-low

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values, applied immediately, including mid-operation:
  - State IDLE.
  - CE_N, WE_N, OE_N, LB_N, UB_N all 1.
  - SRAM_DQ high-Z; SRAM_ADDR 0.
  - o_rdata 0, o_ack 0, o_busy 0.
  - No partial write completes after reset is asserted.
- Request acceptance:
  - A request is accepted on the rising edge where state=IDLE and i_req=1.
  - i_wren, i_addr[18:2], i_wdata and i_bmask are latched at that edge, so the requester may change them afterwards.
  - i_req while o_busy=1 is dropped silently; it is not queued.
- FSM states: IDLE, LO_STB, LO_REC, HI_STB, HI_REC, DONE.
  - IDLE to LO_STB on accept.
  - LO_STB lasts WAIT_CYC cycles, tracked by a down-counter, then goes to LO_REC.
  - LO_REC lasts 1 cycle, then goes to HI_STB.
  - HI_STB lasts WAIT_CYC cycles, then goes to HI_REC.
  - HI_REC lasts 1 cycle, then goes to DONE.
  - DONE lasts 1 cycle, then goes to IDLE.
- Addressing:
  - SRAM_ADDR = {addr[18:2],1'b0} in LO_* states.
  - SRAM_ADDR = {addr[18:2],1'b1} in HI_* states.
- Strobes:
  - CE_N=0 in all LO_*/HI_* states; CE_N=1 in IDLE and DONE.
  - Write: WE_N=0 only in *_STB states; OE_N=1 throughout.
  - Read: OE_N=0 only in *_STB states; WE_N=1 throughout.
- Byte lanes:
  - Write, LO phase: LB_N=~bmask[0], UB_N=~bmask[1].
  - Write, HI phase: LB_N=~bmask[2], UB_N=~bmask[3].
  - Read: LB_N=UB_N=0 in both phases.
- Data bus:
  - On writes, SRAM_DQ drives wdata[15:0] in LO_STB/LO_REC and wdata[31:16] in HI_STB/HI_REC. Data is held through the REC cycle for hold time.
  - On reads, and in every other state, SRAM_DQ is high-Z.
- Read capture:
  - SRAM_DQ is registered into rdata[15:0] on the edge that ends the last LO_STB cycle.
  - SRAM_DQ is registered into rdata[31:16] on the edge that ends the last HI_STB cycle.
- Completion:
  - o_ack=1 for exactly one cycle, in DONE.
  - Baseline latency from the accept edge to o_ack high is 2*(WAIT_CYC+1)+1 cycles, i.e. 5 for WAIT_CYC=1.
  - o_rdata holds its value until the next read's capture; writes do not alter o_rdata.
- Back-to-back requests: the earliest next accept is the cycle after DONE.
- Write with bmask=0: both phases still run with LB_N=UB_N=1, so no bytes are written (see Optional Feature for skipping).

Optional Feature:
SRAM_CTRL_MASKSKIP_EN
- Defined:
  - Writes skip any halfword phase whose two mask bits are both 0.
  - LO phase skipped: IDLE goes directly to HI_STB.
  - HI phase skipped: LO_REC goes directly to DONE.
  - bmask=0: IDLE goes directly to DONE, and o_ack follows 1 cycle after accept with no SRAM activity.
  - Reads are unaffected.
- Undefined: both phases always run, as described in Behaviour.

Test Plan:
1. Assert i_rst mid-cycle during a write's LO_STB.
   -> All outputs reach reset values immediately, before the next edge.
   -> A following read request completes normally.
2. WAIT_CYC=1: write addr 0x4, data 0xDEADBEEF, bmask 0xF.
   -> SRAM_ADDR 0x00002 with DQ 0xBEEF, then 0x00003 with DQ 0xDEAD.
   -> WE_N low 1 cycle per phase; o_ack 5 cycles after accept.
3. Read addr 0x4 after test 2.
   -> OE_N low 1 cycle per phase, LB_N=UB_N=0.
   -> o_rdata=0xDEADBEEF when o_ack=1.
4. Write addr 0x4, data 0x0000AB00, bmask 0x2, then read addr 0x4.
   -> LO phase drives LB_N=1, UB_N=0.
   -> Read returns 0xDEADABEF.
   -> Write ack after 5 cycles with the macro undefined; after 3 cycles with SRAM_CTRL_MASKSKIP_EN defined, with no CE_N pulse at halfword 0x00003.
5. Pulse i_req 2 cycles after an accept.
   -> The pulse is ignored and exactly one o_ack occurs.
   -> With WAIT_CYC=3, o_ack comes 9 cycles after accept.
6. Write bmask 0x0.
   -> With the macro defined: o_ack 1 cycle after accept, CE_N never low.
   -> With the macro undefined: 5 cycles, LB_N=UB_N=1 throughout, SRAM contents unchanged.
